// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake engine: direction and state
// encodings plus small constant-evaluable utilities.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_R = 2'd0,
        DIR_D = 2'd1,
        DIR_L = 2'd2,
        DIR_U = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_e;

    // Opposite directions differ only in the upper encoding bit.
    function automatic dir_e opposite_dir(input dir_e d);
        return dir_e'(d ^ 2'b10);
    endfunction

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                result++;
                v = v >> 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/snake_seg_match.sv
// Parallel match of one cell coordinate against every segment slot; slots
// at or beyond the supplied limit are masked out.
module snake_seg_match
    import snake_pkg::*;
#(
    parameter int MAX_LEN = 64,
    parameter int COORD_W = 6,
    parameter int LEN_W   = clog2(MAX_LEN + 1)
) (
    input  logic [MAX_LEN-1:0][COORD_W-1:0] seg_x,
    input  logic [MAX_LEN-1:0][COORD_W-1:0] seg_y,
    input  logic [LEN_W-1:0]                limit,
    input  logic [COORD_W-1:0]              query_x,
    input  logic [COORD_W-1:0]              query_y,
    output logic                            match
);

    logic [MAX_LEN-1:0] hit;

    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_cmp
        localparam logic [LEN_W-1:0] SEG_IDX = LEN_W'(gi);
        assign hit[gi] = (SEG_IDX < limit)
                       && (seg_x[gi] == query_x)
                       && (seg_y[gi] == query_y);
    end

    assign match = |hit;

endmodule

// File: rtl/snake_engine.sv
// Snake body store and movement engine: advances the head per step strobe,
// resolves food, growth, self-collision and edges, and answers cell queries.
module snake_engine
    import snake_pkg::*;
#(
    parameter int MAX_LEN  = 64,
    parameter int COORD_W  = 6,
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int INIT_LEN = 3,
    parameter int WRAP     = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           step,
    input  logic                           start,
    input  logic [1:0]                     dir_in,
    input  logic [COORD_W-1:0]             food_x,
    input  logic [COORD_W-1:0]             food_y,
    input  logic [COORD_W-1:0]             pix_x,
    input  logic [COORD_W-1:0]             pix_y,
    output logic [COORD_W-1:0]             head_x,
    output logic [COORD_W-1:0]             head_y,
    output logic [$clog2(MAX_LEN+1)-1:0]   length,
    output logic                           bite,
    output logic                           dead,
    output logic                           pix_snake,
    output logic                           pix_head
);

    localparam int                 LEN_W    = $clog2(MAX_LEN + 1);
    localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX    = COORD_W'(GRID_H - 1);
    localparam logic [LEN_W-1:0]   LEN_INIT = LEN_W'(INIT_LEN);
    localparam logic [LEN_W-1:0]   LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);
    localparam bit                 WRAP_EN  = (WRAP != 0);

    state_e                          state_reg;
    state_e                          state_next;
    dir_e                            cur_dir_reg;
    dir_e                            req_dir;
    dir_e                            eff_dir;
    logic [LEN_W-1:0]                length_reg;
    logic                            bite_reg;
    logic                            pix_snake_reg;
    logic                            pix_head_reg;

    logic [MAX_LEN-1:0][COORD_W-1:0] seg_x_reg;
    logic [MAX_LEN-1:0][COORD_W-1:0] seg_y_reg;
    logic [MAX_LEN-1:0][COORD_W-1:0] seg_x_init;
    logic [MAX_LEN-1:0][COORD_W-1:0] seg_y_init;
    logic [MAX_LEN-1:0][COORD_W-1:0] seg_x_shift;
    logic [MAX_LEN-1:0][COORD_W-1:0] seg_y_shift;

    logic [COORD_W-1:0]              nxt_x;
    logic [COORD_W-1:0]              nxt_y;
    logic                            edge_cross;
    logic                            hit_wall;
    logic                            grow;
    logic                            collide;
    logic                            pix_match;
    logic [LEN_W-1:0]                col_limit;

    logic                            do_init;
    logic                            do_move;
    logic                            dead_state;

    // Reset layout and one-cell shift of the body, built slot by slot.
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_seg
        localparam logic [COORD_W-1:0] INIT_X = COORD_W'(GRID_W / 2 - gi);
        localparam logic [COORD_W-1:0] INIT_Y = COORD_W'(GRID_H / 2);
        assign seg_x_init[gi] = INIT_X;
        assign seg_y_init[gi] = INIT_Y;
        if (gi == 0) begin : g_head
            assign seg_x_shift[gi] = nxt_x;
            assign seg_y_shift[gi] = nxt_y;
        end else begin : g_body
            assign seg_x_shift[gi] = seg_x_reg[gi-1];
            assign seg_y_shift[gi] = seg_y_reg[gi-1];
        end
    end

    // A request to reverse onto the neck is ignored.
    assign req_dir = dir_e'(dir_in);
    assign eff_dir = (req_dir == opposite_dir(cur_dir_reg)) ? cur_dir_reg : req_dir;

    always_comb begin
        nxt_x      = seg_x_reg[0];
        nxt_y      = seg_y_reg[0];
        edge_cross = 1'b0;
        case (eff_dir)
            DIR_R: begin
                if (seg_x_reg[0] == X_MAX) begin
                    nxt_x      = '0;
                    edge_cross = 1'b1;
                end else begin
                    nxt_x = seg_x_reg[0] + ONE;
                end
            end
            DIR_L: begin
                if (seg_x_reg[0] == '0) begin
                    nxt_x      = X_MAX;
                    edge_cross = 1'b1;
                end else begin
                    nxt_x = seg_x_reg[0] - ONE;
                end
            end
            DIR_D: begin
                if (seg_y_reg[0] == Y_MAX) begin
                    nxt_y      = '0;
                    edge_cross = 1'b1;
                end else begin
                    nxt_y = seg_y_reg[0] + ONE;
                end
            end
            default: begin
                if (seg_y_reg[0] == '0) begin
                    nxt_y      = Y_MAX;
                    edge_cross = 1'b1;
                end else begin
                    nxt_y = seg_y_reg[0] - ONE;
                end
            end
        endcase
    end

    assign hit_wall = edge_cross && !WRAP_EN;
    assign grow     = (nxt_x == food_x) && (nxt_y == food_y);

    // Without growth the tail vacates its cell this step, so it is excluded.
    assign col_limit = grow ? length_reg : (length_reg - LEN_W'(1));

    snake_seg_match #(
        .MAX_LEN (MAX_LEN),
        .COORD_W (COORD_W),
        .LEN_W   (LEN_W)
    ) u_col_match (
        .seg_x   (seg_x_reg),
        .seg_y   (seg_y_reg),
        .limit   (col_limit),
        .query_x (nxt_x),
        .query_y (nxt_y),
        .match   (collide)
    );

    snake_seg_match #(
        .MAX_LEN (MAX_LEN),
        .COORD_W (COORD_W),
        .LEN_W   (LEN_W)
    ) u_pix_match (
        .seg_x   (seg_x_reg),
        .seg_y   (seg_y_reg),
        .limit   (length_reg),
        .query_x (pix_x),
        .query_y (pix_y),
        .match   (pix_match)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (step && (hit_wall || collide)) begin
                    state_next = ST_DEAD;
                end
            end
            ST_DEAD: begin
                if (start) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        do_init    = 1'b0;
        do_move    = 1'b0;
        dead_state = 1'b0;
        case (state_reg)
            ST_RUN: begin
                do_move = step && !hit_wall && !collide;
            end
            ST_DEAD: begin
                dead_state = 1'b1;
                do_init    = start;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || do_init) begin
            seg_x_reg   <= seg_x_init;
            seg_y_reg   <= seg_y_init;
            length_reg  <= LEN_INIT;
            cur_dir_reg <= DIR_R;
        end else if (do_move) begin
            seg_x_reg   <= seg_x_shift;
            seg_y_reg   <= seg_y_shift;
            cur_dir_reg <= eff_dir;
            if (grow && (length_reg != LEN_MAX)) begin
                length_reg <= length_reg + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bite_reg      <= 1'b0;
            pix_snake_reg <= 1'b0;
            pix_head_reg  <= 1'b0;
        end else begin
            bite_reg      <= do_move && grow;
            pix_snake_reg <= pix_match;
            pix_head_reg  <= (pix_x == seg_x_reg[0]) && (pix_y == seg_y_reg[0]);
        end
    end

    assign head_x    = seg_x_reg[0];
    assign head_y    = seg_y_reg[0];
    assign length    = length_reg;
    assign bite      = bite_reg;
    assign dead      = dead_state;
    assign pix_snake = pix_snake_reg;
    assign pix_head  = pix_head_reg;

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine: default build (a), wall-death build (b)
// and a MAX_LEN=4 build (c) driven by one shared stimulus stream.
module tb_snake_engine;

    logic       clk;
    logic       reset;
    logic       step;
    logic       start;
    logic [1:0] dir_in;
    logic [5:0] food_x;
    logic [5:0] food_y;
    logic [5:0] pix_x;
    logic [5:0] pix_y;

    logic [5:0] a_head_x, a_head_y, b_head_x, b_head_y, c_head_x, c_head_y;
    logic [6:0] a_length, b_length;
    logic [2:0] c_length;
    logic a_bite, a_dead, a_pix_snake, a_pix_head;
    logic b_bite, b_dead, b_pix_snake, b_pix_head;
    logic c_bite, c_dead, c_pix_snake, c_pix_head;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    snake_engine #(.WRAP(1)) dut_a (
        .clk(clk), .reset(reset), .step(step), .start(start), .dir_in(dir_in),
        .food_x(food_x), .food_y(food_y), .pix_x(pix_x), .pix_y(pix_y),
        .head_x(a_head_x), .head_y(a_head_y), .length(a_length), .bite(a_bite),
        .dead(a_dead), .pix_snake(a_pix_snake), .pix_head(a_pix_head)
    );

    snake_engine #(.WRAP(0)) dut_b (
        .clk(clk), .reset(reset), .step(step), .start(start), .dir_in(dir_in),
        .food_x(food_x), .food_y(food_y), .pix_x(pix_x), .pix_y(pix_y),
        .head_x(b_head_x), .head_y(b_head_y), .length(b_length), .bite(b_bite),
        .dead(b_dead), .pix_snake(b_pix_snake), .pix_head(b_pix_head)
    );

    snake_engine #(.MAX_LEN(4)) dut_c (
        .clk(clk), .reset(reset), .step(step), .start(start), .dir_in(dir_in),
        .food_x(food_x), .food_y(food_y), .pix_x(pix_x), .pix_y(pix_y),
        .head_x(c_head_x), .head_y(c_head_y), .length(c_length), .bite(c_bite),
        .dead(c_dead), .pix_snake(c_pix_snake), .pix_head(c_pix_head)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_step(input logic [1:0] d);
        dir_in = d;
        step   = 1'b1;
        tick();
        step   = 1'b0;
        $display("step dir=%0d a_head=(%0d,%0d) a_len=%0d a_bite=%0d a_dead=%0d b_dead=%0d c_len=%0d",
                 d, a_head_x, a_head_y, a_length, a_bite, a_dead, b_dead, c_length);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset  = 1'b1;
        step   = 1'b0;
        start  = 1'b0;
        dir_in = 2'd0;
        food_x = 6'd10;
        food_y = 6'd29;
        pix_x  = 6'd0;
        pix_y  = 6'd0;
        tick();
        tick();
        check("rst_head_x", a_head_x, 20);
        check("rst_head_y", a_head_y, 15);
        check("rst_len", a_length, 3);
        check("rst_bite", a_bite, 0);
        check("rst_dead", a_dead, 0);
        check("rst_pix_snake", a_pix_snake, 0);
        check("rst_pix_head", a_pix_head, 0);
        check("rst_c_len", c_length, 3);

        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;

        do_step(2'd0);
        check("step1_head_x", a_head_x, 21);
        check("step1_head_y", a_head_y, 15);
        check("step1_len", a_length, 3);

        pix_x = 6'd18; pix_y = 6'd15;
        tick();
        check("pix_18_snake", a_pix_snake, 0);
        pix_x = 6'd19;
        tick();
        check("pix_19_snake", a_pix_snake, 1);
        check("pix_19_head", a_pix_head, 0);
        pix_x = 6'd21;
        tick();
        check("pix_21_head", a_pix_head, 1);

        food_x = 6'd22; food_y = 6'd15;
        do_step(2'd0);
        food_x = 6'd10; food_y = 6'd29;
        check("eat1_bite", a_bite, 1);
        check("eat1_len", a_length, 4);
        check("eat1_head_x", a_head_x, 22);
        check("eat1_c_len", c_length, 4);
        tick();
        check("eat1_bite_drop", a_bite, 0);

        do_step(2'd2);
        check("rev_head_x", a_head_x, 23);
        check("rev_head_y", a_head_y, 15);
        check("rev_bite", a_bite, 0);
        do_step(2'd0);
        check("rev_dir_kept", a_head_x, 24);

        food_x = 6'd25; food_y = 6'd15;
        do_step(2'd0);
        food_x = 6'd10; food_y = 6'd29;
        check("eat2_len", a_length, 5);
        check("eat2_bite", a_bite, 1);
        check("sat_c_bite", c_bite, 1);
        check("sat_c_len", c_length, 4);

        do_step(2'd1);
        do_step(2'd2);
        check("sq_pre_head_x", a_head_x, 24);
        check("sq_pre_head_y", a_head_y, 16);
        do_step(2'd3);
        check("sq5_dead", a_dead, 1);
        check("sq5_head_x", a_head_x, 24);
        check("sq5_head_y", a_head_y, 16);
        check("sq5_len", a_length, 5);
        check("sq5_bite", a_bite, 0);
        check("sq4_c_dead", c_dead, 0);
        check("sq4_c_head_y", c_head_y, 15);

        do_step(2'd3);
        check("dead_frozen_y", a_head_y, 16);

        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_dead", a_dead, 0);
        check("restart_head_x", a_head_x, 20);
        check("restart_len", a_length, 3);
        check("run_start_ignored_c", c_head_x, 24);

        for (int i = 0; i < 19; i++) begin
            do_step(2'd0);
        end
        check("edge_a_head_x", a_head_x, 39);
        check("edge_b_head_x", b_head_x, 39);
        do_step(2'd0);
        check("wrap_a_head_x", a_head_x, 0);
        check("wrap_a_head_y", a_head_y, 15);
        check("wrap_a_dead", a_dead, 0);
        check("wall_b_dead", b_dead, 1);
        check("wall_b_head_x", b_head_x, 39);

        reset = 1'b1;
        step  = 1'b1;
        tick();
        reset = 1'b0;
        step  = 1'b0;
        check("midrst_head_x", a_head_x, 20);
        check("midrst_len", a_length, 3);
        check("midrst_b_dead", b_dead, 0);
        check("midrst_c_len", c_length, 3);
        check("midrst_c_head_x", c_head_x, 20);

        do_step(2'd0);
        check("idle_step_ignored", a_head_x, 20);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
